pipeline_trace_gen: RTL and testbench

Synthesizable trace producer for the five-stage WISC CPU. It runs a shadow pipeline alongside IF/ID, ID/EX, EX/MEM and MEM/WB, and applies the same stall and flush rules as the real pipeline. Each instruction receives a tag at fetch. Every instruction that reaches write-back emits one retirement record through a buffered valid/ready stream, which feeds the pipeline checker/printer on the consuming side.

---
 rtl/pipeline_trace_gen.sv | 137 +++++++++++++
 tb/tb_pipeline_trace_gen.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_trace_gen.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_trace_gen
// Brief   : Shadow IF/ID..MEM/WB pipeline that tags fetches and streams
//           retirement records through a small valid/ready FIFO.
// Revision: 1.0
// ============================================================================
module pipeline_trace_gen #(
   parameter int DEPTH = 8,
   parameter int TAG_W = 8,
   parameter int CYC_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             if_valid,
   input  logic [15:0]      if_pc,
   input  logic [15:0]      if_instr,
   input  logic             stall,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [TAG_W-1:0] out_tag,
   output logic [15:0]      out_pc,
   output logic [15:0]      out_instr,
   output logic [CYC_W-1:0] out_fetch_cyc,
   output logic [CYC_W-1:0] out_wb_cyc,
   output logic             overflow,
   output logic [7:0]       drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int RW = TAG_W + 32 + 2 * CYC_W;

   logic [CYC_W-1:0] cyc;
   logic [TAG_W-1:0] tag_ctr;

   logic             s1_v, s2_v, s3_v, s4_v;
   logic [TAG_W-1:0] s1_tag, s2_tag, s3_tag, s4_tag;
   logic [15:0]      s1_pc, s2_pc, s3_pc, s4_pc;
   logic [15:0]      s1_instr, s2_instr, s3_instr, s4_instr;
   logic [CYC_W-1:0] s1_fcyc, s2_fcyc, s3_fcyc, s4_fcyc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc      <= '0;
         tag_ctr  <= '0;
         s1_v     <= 1'b0;
         s2_v     <= 1'b0;
         s3_v     <= 1'b0;
         s4_v     <= 1'b0;
         s1_tag   <= '0;  s2_tag   <= '0;  s3_tag   <= '0;  s4_tag   <= '0;
         s1_pc    <= '0;  s2_pc    <= '0;  s3_pc    <= '0;  s4_pc    <= '0;
         s1_instr <= '0;  s2_instr <= '0;  s3_instr <= '0;  s4_instr <= '0;
         s1_fcyc  <= '0;  s2_fcyc  <= '0;  s3_fcyc  <= '0;  s4_fcyc  <= '0;
      end else begin
         cyc <= cyc + 1'b1;

         // Flush dominates: the fetch in flight is squashed and consumes no tag.
         if (flush) begin
            s1_v <= 1'b0;
         end else if (!stall) begin
            s1_v     <= if_valid;
            s1_tag   <= tag_ctr;
            s1_pc    <= if_pc;
            s1_instr <= if_instr;
            s1_fcyc  <= cyc;
            if (if_valid) begin
               tag_ctr <= tag_ctr + 1'b1;
            end
         end

         s2_v     <= stall ? 1'b0 : s1_v;
         s2_tag   <= s1_tag;
         s2_pc    <= s1_pc;
         s2_instr <= s1_instr;
         s2_fcyc  <= s1_fcyc;

         s3_v     <= s2_v;
         s3_tag   <= s2_tag;
         s3_pc    <= s2_pc;
         s3_instr <= s2_instr;
         s3_fcyc  <= s2_fcyc;

         s4_v     <= s3_v;
         s4_tag   <= s3_tag;
         s4_pc    <= s3_pc;
         s4_instr <= s3_instr;
         s4_fcyc  <= s3_fcyc;
      end
   end

   // Retirement FIFO: pointers carry one extra wrap bit to tell full from empty.
   logic [RW-1:0] mem [DEPTH];
   logic [AW:0]   wr_ptr, rd_ptr;
   logic          empty, full, pop, push, accept, drop;
   logic [RW-1:0] rec, head;

   assign empty  = (wr_ptr == rd_ptr);
   assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop    = !empty && out_ready;
   assign push   = s4_v;
   assign accept = push && (!full || pop);
   assign drop   = push && full && !pop;
   assign rec    = {s4_tag, s4_pc, s4_instr, s4_fcyc, cyc};
   assign head   = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
         drop_cnt <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (accept) begin
            mem[wr_ptr[AW-1:0]] <= rec;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF) begin
               drop_cnt <= drop_cnt + 1'b1;
            end
         end
      end
   end

   assign out_valid = !empty;
   assign {out_tag, out_pc, out_instr, out_fetch_cyc, out_wb_cyc} = head;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_trace_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipeline_trace_gen
// Brief   : Directed and randomized bench for pipeline_trace_gen against a
//           holding-slot plus retire-time delay-line model.
// Revision: 1.0
// ============================================================================
module tb_pipeline_trace_gen;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_valid = 1'b0, stall = 1'b0, flush = 1'b0, out_ready = 1'b0;
   logic [15:0] if_pc = '0, if_instr = '0;
   logic        out_valid, overflow;
   logic [7:0]  out_tag, drop_cnt;
   logic [15:0] out_pc, out_instr, out_fetch_cyc, out_wb_cyc;

   pipeline_trace_gen #(.DEPTH(DEPTH), .TAG_W(8), .CYC_W(16)) dut (
      .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
      .stall(stall), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_tag(out_tag), .out_pc(out_pc), .out_instr(out_instr),
      .out_fetch_cyc(out_fetch_cyc), .out_wb_cyc(out_wb_cyc),
      .overflow(overflow), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  tag;
      logic [15:0] pc, instr, f, w;
      int          due;
   } rec_t;

   rec_t        flight[$], mfifo[$], log_q[$];
   rec_t        occ;
   bit          occ_v, m_ovf;
   logic [7:0]  m_tag;
   int          m_drop, ncyc, passed = 0, total = 0;
   logic [15:0] pc_r;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ncyc);
   endtask

   task automatic model_reset();
      flight.delete(); mfifo.delete(); log_q.delete();
      occ_v = 0; m_tag = 0; m_drop = 0; m_ovf = 0; ncyc = 0; pc_r = 0;
   endtask

   // One cycle of the reference: FIFO pop/push, then the IF/ID holding slot.
   task automatic model_step();
      rec_t r;
      if (mfifo.size() > 0 && out_ready) void'(mfifo.pop_front());
      if (flight.size() > 0 && flight[0].due == ncyc) begin
         r = flight.pop_front();
         if (mfifo.size() < DEPTH) mfifo.push_back(r);
         else begin
            m_ovf = 1;
            if (m_drop < 255) m_drop++;
         end
      end
      if (occ_v && !stall) begin
         r = occ; r.due = ncyc + 3; r.w = 16'(ncyc + 3);
         flight.push_back(r);
         occ_v = 0;
      end else if (occ_v && flush) begin
         occ_v = 0;
      end
      if (!stall && !flush && if_valid) begin
         occ.tag = m_tag; occ.pc = if_pc; occ.instr = if_instr;
         occ.f = 16'(ncyc); occ.w = '0; occ.due = 0;
         occ_v = 1;
         m_tag++;
      end
      ncyc++;
   endtask

   task automatic compare();
      chk("out_valid", 32'(out_valid), 32'(mfifo.size() > 0));
      if (out_valid && mfifo.size() > 0) begin
         chk("out_tag", 32'(out_tag), 32'(mfifo[0].tag));
         chk("out_pc", 32'(out_pc), 32'(mfifo[0].pc));
         chk("out_instr", 32'(out_instr), 32'(mfifo[0].instr));
         chk("out_fetch_cyc", 32'(out_fetch_cyc), 32'(mfifo[0].f));
         chk("out_wb_cyc", 32'(out_wb_cyc), 32'(mfifo[0].w));
      end
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
   endtask

   // Called at a falling edge: check, drive, log a handshake, advance model.
   task automatic step(input bit iv, input bit st, input bit fl, input bit rdy);
      rec_t r;
      compare();
      if_valid = iv; if_pc = pc_r; if_instr = 16'($urandom);
      stall = st; flush = fl; out_ready = rdy;
      if (out_valid && rdy) begin
         r.tag = out_tag; r.pc = out_pc; r.instr = out_instr;
         r.f = out_fetch_cyc; r.w = out_wb_cyc; r.due = ncyc;
         log_q.push_back(r);
      end
      model_step();
      if (iv && !st) pc_r += 16'd2;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1; if_valid = 0; stall = 0; flush = 0; out_ready = 0;
      #1 chk("rst_out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      rst = 0;
      model_reset();
   endtask

   initial begin
      @(negedge clk);
      do_reset();
      chk("rst_out_tag", 32'(out_tag), 0);
      chk("rst_out_pc", 32'(out_pc), 0);
      chk("rst_out_wb_cyc", 32'(out_wb_cyc), 0);
      chk("rst_drop_cnt", 32'(drop_cnt), 0);

      // Straight line with one load-use stall and one branch flush.
      for (int n = 0; n < 31; n++) step(n >= 1, n == 4, n == 12, 1'b1);
      chk("p1_count", 32'(log_q.size() >= 11), 1);
      if (log_q.size() >= 11) begin
         chk("first_tag", 32'(log_q[0].tag), 0);
         chk("first_pc", 32'(log_q[0].pc), 0);
         chk("first_fcyc", 32'(log_q[0].f), 1);
         chk("first_wbcyc", 32'(log_q[0].w), 5);
         chk("first_out_cycle", 32'(log_q[0].due), 6);
         chk("second_out_cycle", 32'(log_q[1].due), 7);
         chk("stall_tag", 32'(log_q[2].tag), 2);
         chk("stall_pc", 32'(log_q[2].pc), 4);
         chk("stall_latency", 32'(16'(log_q[2].w - log_q[2].f)), 5);
         chk("stall_out_cycle", 32'(log_q[2].due), 9);
         chk("after_stall_cycle", 32'(log_q[3].due), 10);
         chk("pre_flush_cycle", 32'(log_q[9].due), 16);
         chk("flush_next_tag", 32'(log_q[10].tag), 10);
         chk("flush_next_fcyc", 32'(log_q[10].f), 13);
         chk("flush_gap_cycle", 32'(log_q[10].due), 18);
      end

      // Backpressure for DEPTH+3 retirements, then ready in the cycle of a push.
      do_reset();
      for (int n = 0; n < 45; n++) step(n >= 1 && n <= 12, 1'b0, 1'b0, n >= 16);
      chk("bp_overflow", 32'(overflow), 1);
      chk("bp_drop_cnt", 32'(drop_cnt), 3);
      chk("bp_count", 32'(log_q.size()), 9);
      if (log_q.size() == 9) begin
         chk("bp_tag7", 32'(log_q[7].tag), 7);
         chk("bp_tag11", 32'(log_q[8].tag), 11);
      end

      // Randomized traffic.
      do_reset();
      for (int n = 0; n < 1500; n++)
         step($urandom_range(0, 9) < 8, $urandom_range(0, 99) < 15,
              $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 70);

      // Tag wrap.
      do_reset();
      for (int n = 0; n < 300; n++) step(n >= 1, 1'b0, 1'b0, 1'b1);
      chk("wrap_count", 32'(log_q.size() > 256), 1);
      if (log_q.size() > 256) begin
         chk("wrap_tag255", 32'(log_q[255].tag), 255);
         chk("wrap_tag0", 32'(log_q[256].tag), 0);
      end

      // Reset with three records buffered.
      do_reset();
      for (int n = 0; n < 10; n++) step(n >= 1 && n <= 3, 1'b0, 1'b0, 1'b0);
      chk("buffered_valid", 32'(out_valid), 1);
      chk("buffered_model", 32'(mfifo.size()), 3);
      do_reset();
      for (int n = 0; n < 10; n++) step(n >= 1, 1'b0, 1'b0, 1'b1);
      chk("post_rst_count", 32'(log_q.size() > 0), 1);
      if (log_q.size() > 0) begin
         chk("post_rst_tag", 32'(log_q[0].tag), 0);
         chk("post_rst_fcyc", 32'(log_q[0].f), 1);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
